// File: rtl/hazard_pkg.sv
// Shared encodings for the five-stage pipeline hazard controller:
// forwarding selects, controller states and the control-field values it decodes.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hz_state_t;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
  localparam logic [1:0] PCSRC_SEQ      = 2'b00;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding comparator for one execute-stage source operand.
// The memory stage is the younger producer, so it wins over writeback.
module fwd_sel (
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic [2:0] reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic [2:0] reg_write_w_i,
  output logic [1:0] sel_o
);
  import hazard_pkg::*;

  fwd_sel_t sel;

  // x0 is hardwired to zero, so a zero source never takes a forwarded value.
  always_comb begin
    sel = FWD_RF;
    if (rs_i != 5'd0) begin
      if ((reg_write_m_i != 3'd0) && (rd_m_i == rs_i)) begin
        sel = FWD_M;
      end else if ((reg_write_w_i != 3'd0) && (rd_w_i == rs_i)) begin
        sel = FWD_W;
      end
    end
  end

  assign sel_o = sel;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, redirect flush,
// freeze on outstanding data-memory access with a watchdog, and perf counters.
module hazard_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            Rs1D_i,
  input  logic [4:0]            Rs2D_i,
  input  logic [4:0]            Rs1E_i,
  input  logic [4:0]            Rs2E_i,
  input  logic [4:0]            RdE_i,
  input  logic [1:0]            ResultSrcE_i,
  input  logic [4:0]            RdM_i,
  input  logic [4:0]            RdW_i,
  input  logic [2:0]            RegWriteM_i,
  input  logic [2:0]            RegWriteW_i,
  input  logic [1:0]            PCSrcE_i,
  input  logic                  MemAccessM_i,
  input  logic                  MemReadyM_i,
  output logic [1:0]            FowardAE_o,
  output logic [1:0]            FowardBE_o,
  output logic                  Fen_o,
  output logic                  Den_o,
  output logic                  Een_o,
  output logic                  Men_o,
  output logic                  Drst_o,
  output logic                  Erst_o,
  output logic                  Wrst_o,
  output logic [DATA_WIDTH-1:0] stall_cnt_o,
  output logic [DATA_WIDTH-1:0] flush_cnt_o,
  output logic                  err_o
);
  import hazard_pkg::*;

  localparam int WaitW = $clog2(MEM_TIMEOUT + 1);

  hz_state_t             state_q, state_d;
  logic [WaitW-1:0]      waitCnt_q, waitCnt_d, waitInc;
  logic [DATA_WIDTH-1:0] stallCnt_q, stallCnt_d, flushCnt_q, flushCnt_d;
  logic                  err_q;
  logic                  redirect, loadUse, missStart, flushTaken;

  fwd_sel u_fwdA (
    .rs_i          (Rs1E_i),
    .rd_m_i        (RdM_i),
    .reg_write_m_i (RegWriteM_i),
    .rd_w_i        (RdW_i),
    .reg_write_w_i (RegWriteW_i),
    .sel_o         (FowardAE_o)
  );

  fwd_sel u_fwdB (
    .rs_i          (Rs2E_i),
    .rd_m_i        (RdM_i),
    .reg_write_m_i (RegWriteM_i),
    .rd_w_i        (RdW_i),
    .reg_write_w_i (RegWriteW_i),
    .sel_o         (FowardBE_o)
  );

  assign redirect  = (PCSrcE_i != PCSRC_SEQ);
  assign loadUse   = (ResultSrcE_i == RESULTSRC_LOAD) && (RdE_i != 5'd0) &&
                     ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  assign missStart = MemAccessM_i && !MemReadyM_i;
  assign waitInc   = waitCnt_q + WaitW'(1);

  // The cycle that detects a miss is already frozen, so it counts as the first wait cycle.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = '0;
    Fen_o      = 1'b1;
    Den_o      = 1'b1;
    Een_o      = 1'b1;
    Men_o      = 1'b1;
    Drst_o     = 1'b0;
    Erst_o     = 1'b0;
    Wrst_o     = 1'b0;
    flushTaken = 1'b0;
    if (state_q == ERROR) begin
      {Fen_o, Den_o, Een_o, Men_o} = 4'b0000;
      Wrst_o = 1'b1;
    end else if ((state_q == MEM_WAIT) && !MemReadyM_i) begin
      {Fen_o, Den_o, Een_o, Men_o} = 4'b0000;
      Wrst_o = 1'b1;
      if (waitInc >= WaitW'(MEM_TIMEOUT)) begin
        state_d = ERROR;
      end else begin
        state_d   = MEM_WAIT;
        waitCnt_d = waitInc;
      end
    end else begin
      state_d = RUN;
      if (missStart) begin
        {Fen_o, Den_o, Een_o, Men_o} = 4'b0000;
        Wrst_o = 1'b1;
        if (MEM_TIMEOUT <= 1) begin
          state_d = ERROR;
        end else begin
          state_d   = MEM_WAIT;
          waitCnt_d = WaitW'(1);
        end
      end else if (redirect) begin
        Drst_o     = 1'b1;
        Erst_o     = 1'b1;
        flushTaken = 1'b1;
      end else if (loadUse) begin
        Fen_o  = 1'b0;
        Den_o  = 1'b0;
        Erst_o = 1'b1;
      end
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (!Fen_o && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + DATA_WIDTH'(1);
    if (flushTaken && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + DATA_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      waitCnt_q  <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
      err_q      <= (state_d == ERROR);
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_hazard_unit;

  localparam int     Timeout = 64;
  localparam longint SatMax  = 64'hFFFF_FFFF;

  typedef struct {
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0] resultSrcE, pcSrcE;
    logic [2:0] regWriteM, regWriteW;
    logic       memAccessM, memReadyM;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [4:0]  Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic [1:0]  ResultSrcE = '0, PCSrcE = '0;
  logic [2:0]  RegWriteM = '0, RegWriteW = '0;
  logic        MemAccessM = 1'b0, MemReadyM = 1'b1;
  logic [1:0]  FowardAE, FowardBE;
  logic        Fen, Den, Een, Men, Drst, Erst, Wrst, err;
  logic [31:0] stallCnt, flushCnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: pending miss, consecutive frozen cycles, sticky error, counters.
  bit     mFrozenPrev = 1'b0;
  int     mWaitRun    = 0;
  bit     mErr        = 1'b0;
  longint mStall      = 0;
  longint mFlush      = 0;

  hazard_unit #(.DATA_WIDTH(32), .MEM_TIMEOUT(Timeout)) dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D_i       (Rs1D),
    .Rs2D_i       (Rs2D),
    .Rs1E_i       (Rs1E),
    .Rs2E_i       (Rs2E),
    .RdE_i        (RdE),
    .ResultSrcE_i (ResultSrcE),
    .RdM_i        (RdM),
    .RdW_i        (RdW),
    .RegWriteM_i  (RegWriteM),
    .RegWriteW_i  (RegWriteW),
    .PCSrcE_i     (PCSrcE),
    .MemAccessM_i (MemAccessM),
    .MemReadyM_i  (MemReadyM),
    .FowardAE_o   (FowardAE),
    .FowardBE_o   (FowardBE),
    .Fen_o        (Fen),
    .Den_o        (Den),
    .Een_o        (Een),
    .Men_o        (Men),
    .Drst_o       (Drst),
    .Erst_o       (Erst),
    .Wrst_o       (Wrst),
    .stall_cnt_o  (stallCnt),
    .flush_cnt_o  (flushCnt),
    .err_o        (err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwdModel(input logic [4:0] x, input logic [4:0] rdM,
                                          input logic [2:0] rwM, input logic [4:0] rdW,
                                          input logic [2:0] rwW);
    if (x == 0) return 2'b00;
    if (rwM != 0 && rdM == x) return 2'b10;
    if (rwW != 0 && rdW == x) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.rst = 1'b0;
    s.rs1D = '0; s.rs2D = '0; s.rs1E = '0; s.rs2E = '0;
    s.rdE = '0; s.rdM = '0; s.rdW = '0;
    s.resultSrcE = '0; s.pcSrcE = '0;
    s.regWriteM = '0; s.regWriteW = '0;
    s.memAccessM = 1'b0; s.memReadyM = 1'b1;
    return s;
  endfunction

  // Drive one cycle of inputs just after the rising edge, then settle past the falling edge.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.rst;
    Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E;
    RdE = s.rdE; RdM = s.rdM; RdW = s.rdW;
    ResultSrcE = s.resultSrcE; PCSrcE = s.pcSrcE;
    RegWriteM = s.regWriteM; RegWriteW = s.regWriteW;
    MemAccessM = s.memAccessM; MemReadyM = s.memReadyM;
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    stim_t s;
    s = idleStim();
    s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s.rst = 1'b0;
    applyStimulus(s);
  endtask

  // Compare process: every non-reset cycle, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mFrozenPrev = 1'b0;
        mWaitRun    = 0;
        mErr        = 1'b0;
        mStall      = 0;
        mFlush      = 0;
      end else begin
        bit frozen, redirect, loadUse;
        bit eF, eD, eE, eM, eDr, eEr, eWr;
        redirect = (PCSrcE != 2'b00);
        loadUse  = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
        frozen   = mErr || (!MemReadyM && (MemAccessM || mFrozenPrev));
        {eF, eD, eE, eM, eDr, eEr, eWr} = 7'b1111_000;
        if (frozen)        {eF, eD, eE, eM, eDr, eEr, eWr} = 7'b0000_001;
        else if (redirect) {eDr, eEr} = 2'b11;
        else if (loadUse)  {eF, eD, eEr} = 3'b001;

        checkOutput("FowardAE", 64'(FowardAE), 64'(fwdModel(Rs1E, RdM, RegWriteM, RdW, RegWriteW)));
        checkOutput("FowardBE", 64'(FowardBE), 64'(fwdModel(Rs2E, RdM, RegWriteM, RdW, RegWriteW)));
        checkOutput("Fen", 64'(Fen), 64'(eF));
        checkOutput("Den", 64'(Den), 64'(eD));
        checkOutput("Een", 64'(Een), 64'(eE));
        checkOutput("Men", 64'(Men), 64'(eM));
        checkOutput("Drst", 64'(Drst), 64'(eDr));
        checkOutput("Erst", 64'(Erst), 64'(eEr));
        checkOutput("Wrst", 64'(Wrst), 64'(eWr));
        checkOutput("stall_cnt", 64'(stallCnt), mStall);
        checkOutput("flush_cnt", 64'(flushCnt), mFlush);
        checkOutput("err", 64'(err), 64'(mErr));

        if (!eF && mStall < SatMax) mStall++;
        if (!frozen && redirect && mFlush < SatMax) mFlush++;
        if (frozen && !mErr) begin
          mFrozenPrev = 1'b1;
          mWaitRun++;
          if (mWaitRun >= Timeout) mErr = 1'b1;
        end else if (!frozen) begin
          mFrozenPrev = 1'b0;
          mWaitRun    = 0;
        end
      end
    end
  end

  initial begin
    stim_t s;
    int holdLow;
    $display("[TB] hazard_unit bench starting");

    doReset();
    checkOutput("reset Fen", 64'(Fen), 64'd1);
    checkOutput("reset Wrst", 64'(Wrst), 64'd0);
    checkOutput("reset FowardAE", 64'(FowardAE), 64'd0);
    checkOutput("reset stall_cnt", 64'(stallCnt), 64'd0);
    checkOutput("reset flush_cnt", 64'(flushCnt), 64'd0);
    checkOutput("reset err", 64'(err), 64'd0);

    s = idleStim();
    s.rdM = 5; s.regWriteM = 1; s.rs1E = 5; s.rdW = 5; s.regWriteW = 1;
    applyStimulus(s);
    checkOutput("fwd M wins", 64'(FowardAE), 64'd2);
    checkOutput("fwd B idle", 64'(FowardBE), 64'd0);
    s.rdM = 0;
    applyStimulus(s);
    checkOutput("fwd W", 64'(FowardAE), 64'd1);
    s.rs1E = 0; s.rdM = 0; s.rdW = 0;
    applyStimulus(s);
    checkOutput("fwd x0", 64'(FowardAE), 64'd0);

    s = idleStim();
    s.resultSrcE = 2'b01; s.rdE = 7; s.rs2D = 7;
    applyStimulus(s);
    checkOutput("loaduse Fen", 64'(Fen), 64'd0);
    checkOutput("loaduse Den", 64'(Den), 64'd0);
    checkOutput("loaduse Erst", 64'(Erst), 64'd1);
    checkOutput("loaduse Een", 64'(Een), 64'd1);
    applyStimulus(idleStim());
    checkOutput("loaduse released", 64'(Fen), 64'd1);
    checkOutput("loaduse stall_cnt", 64'(stallCnt), 64'd1);

    s = idleStim();
    s.resultSrcE = 2'b01; s.rdE = 7; s.rs1D = 7; s.pcSrcE = 2'b01;
    applyStimulus(s);
    checkOutput("redirect Drst", 64'(Drst), 64'd1);
    checkOutput("redirect Erst", 64'(Erst), 64'd1);
    checkOutput("redirect over loaduse Fen", 64'(Fen), 64'd1);
    applyStimulus(idleStim());
    checkOutput("redirect one cycle", 64'(Drst), 64'd0);
    checkOutput("redirect flush_cnt", 64'(flushCnt), 64'd1);
    checkOutput("redirect stall_cnt", 64'(stallCnt), 64'd1);

    doReset();
    for (int i = 0; i < 3; i++) begin
      s = idleStim();
      s.memAccessM = 1'b1; s.memReadyM = 1'b0;
      if (i == 1) s.pcSrcE = 2'b10;
      applyStimulus(s);
      checkOutput("memwait Fen", 64'(Fen), 64'd0);
      checkOutput("memwait Men", 64'(Men), 64'd0);
      checkOutput("memwait Wrst", 64'(Wrst), 64'd1);
      checkOutput("memwait Drst", 64'(Drst), 64'd0);
    end
    s = idleStim();
    s.memAccessM = 1'b1; s.memReadyM = 1'b1;
    applyStimulus(s);
    checkOutput("memdone Fen", 64'(Fen), 64'd1);
    checkOutput("memdone Wrst", 64'(Wrst), 64'd0);
    applyStimulus(idleStim());
    checkOutput("memwait stall_cnt", 64'(stallCnt), 64'd3);
    checkOutput("memwait flush_cnt", 64'(flushCnt), 64'd0);

    doReset();
    for (int i = 0; i < Timeout; i++) begin
      s = idleStim();
      s.memAccessM = 1'b1; s.memReadyM = 1'b0;
      applyStimulus(s);
    end
    checkOutput("watchdog not yet", 64'(err), 64'd0);
    applyStimulus(idleStim());
    checkOutput("watchdog err", 64'(err), 64'd1);
    checkOutput("watchdog Fen", 64'(Fen), 64'd0);
    checkOutput("watchdog Wrst", 64'(Wrst), 64'd1);
    checkOutput("watchdog stall_cnt", 64'(stallCnt), 64'd64);
    doReset();
    checkOutput("post-err err", 64'(err), 64'd0);
    checkOutput("post-err stall_cnt", 64'(stallCnt), 64'd0);
    checkOutput("post-err Fen", 64'(Fen), 64'd1);

    holdLow = 0;
    for (int n = 0; n < 3000; n++) begin
      s = idleStim();
      s.rst        = ($urandom_range(0, 399) == 0);
      s.rs1D       = 5'($urandom_range(0, 7));
      s.rs2D       = 5'($urandom_range(0, 7));
      s.rs1E       = 5'($urandom_range(0, 7));
      s.rs2E       = 5'($urandom_range(0, 7));
      s.rdE        = 5'($urandom_range(0, 7));
      s.rdM        = 5'($urandom_range(0, 7));
      s.rdW        = 5'($urandom_range(0, 7));
      s.resultSrcE = 2'($urandom_range(0, 3));
      s.regWriteM  = 3'($urandom_range(0, 7));
      s.regWriteW  = 3'($urandom_range(0, 7));
      s.pcSrcE     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s.memAccessM = ($urandom_range(0, 7) == 0);
      s.memReadyM  = ($urandom_range(0, 3) != 0);
      if (holdLow == 0 && $urandom_range(0, 599) == 0) holdLow = $urandom_range(50, 80);
      if (holdLow > 0) begin
        s.memAccessM = 1'b1;
        s.memReadyM  = 1'b0;
        holdLow--;
      end
      applyStimulus(s);
    end

    applyStimulus(idleStim());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
